world_mem_arbiter: RTL and testbench

Arbiter and scheduler for the single-port world-cell RAM that holds the Langton's ant grid colours. It shares the RAM between two requesters: the display scan reader, which feeds the grid layer of the pixel colour mux, and the ant simulation engine, which does read/write per step. It also sequences whole-grid clears and paces the engine with one step pulse every STEP_DIV frames. It sits between the VGA timing/scan logic, the ant engine and the RAM.

---
 rtl/world_mem_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_world_mem_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/world_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : world_mem_arbiter
//  Description : Shares the single-port world-cell RAM between the display
//                scan reader (strict priority) and the ant engine. It also
//                sweeps the grid to colour 0 on reset or on a clear request,
//                and paces the engine with one step pulse every STEP_DIV
//                frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module world_mem_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 3,
    parameter int STEP_DIV = 1
) (
    input  logic              iclk,
    input  logic              irst,
    input  logic              ivs,
    input  logic              ienable,
    input  logic              iclear,
    input  logic              idisp_req,
    input  logic [ADDR_W-1:0] idisp_addr,
    output logic              odisp_valid,
    output logic [DATA_W-1:0] odisp_data,
    input  logic              iant_req,
    input  logic              iant_we,
    input  logic [ADDR_W-1:0] iant_addr,
    input  logic [DATA_W-1:0] iant_wdata,
    output logic              oant_ack,
    output logic              oant_rvalid,
    output logic [DATA_W-1:0] oant_rdata,
    output logic              ostep,
    output logic              oclear_busy,
    output logic [ADDR_W-1:0] omem_addr,
    output logic              omem_we,
    output logic [DATA_W-1:0] omem_wdata,
    input  logic [DATA_W-1:0] imem_rdata
);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    // Owner of a RAM slot as it travels down the read-return pipeline.
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_DISP = 2'd1;
    localparam logic [1:0] OWN_ANT  = 2'd2;

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    // STEP_DIV=1 would give a zero-width counter; keep one bit that stays 0.
    localparam int              CNT_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);

    state_t              state;
    logic [ADDR_W-1:0]   clear_addr;
    logic [1:0]          tag0_owner;
    logic                tag0_zero;
    logic [1:0]          tag1_owner;
    logic                tag1_zero;
    logic                vs_prev;
    logic [CNT_W-1:0]    frame_cnt;

    logic                clear_go;
    logic                ant_go;
    logic                disp_zero;
    logic                vs_rise;

    // Slot decisions for this cycle: clear beats everything, display beats
    // the ant, and a request is never granted while its ack is still showing.
    always_comb begin
        clear_go  = (state == ST_IDLE) && iclear;
        ant_go    = (state == ST_IDLE) && !iclear && !idisp_req && iant_req && !oant_ack;
        disp_zero = (state == ST_CLEAR) || iclear;
        vs_rise   = ivs && !vs_prev;
    end

    // Arbitration state machine driving the registered RAM port.
    always_ff @(posedge iclk) begin
        if (irst) begin
            state       <= ST_CLEAR;
            clear_addr  <= '0;
            omem_addr   <= '0;
            omem_we     <= 1'b0;
            omem_wdata  <= '0;
            oant_ack    <= 1'b0;
            oclear_busy <= 1'b1;
        end else begin
            oant_ack <= 1'b0;
            case (state)
                ST_CLEAR: begin
                    omem_we     <= 1'b1;
                    omem_wdata  <= '0;
                    omem_addr   <= clear_addr;
                    clear_addr  <= clear_addr + 1'b1;
                    oclear_busy <= 1'b1;
                    if (clear_addr == ADDR_LAST) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    omem_we     <= 1'b0;
                    oclear_busy <= 1'b0;
                    if (clear_go) begin
                        state       <= ST_CLEAR;
                        clear_addr  <= '0;
                        oclear_busy <= 1'b1;
                    end else if (idisp_req) begin
                        omem_addr <= idisp_addr;
                    end else if (ant_go) begin
                        omem_addr  <= iant_addr;
                        omem_we    <= iant_we;
                        omem_wdata <= iant_wdata;
                        oant_ack   <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Two-stage owner tag pipeline matching the RAM read latency, then the
    // registered return to whichever requester issued the slot.
    always_ff @(posedge iclk) begin
        if (irst) begin
            tag0_owner  <= OWN_NONE;
            tag0_zero   <= 1'b0;
            tag1_owner  <= OWN_NONE;
            tag1_zero   <= 1'b0;
            odisp_valid <= 1'b0;
            odisp_data  <= '0;
            oant_rvalid <= 1'b0;
            oant_rdata  <= '0;
        end else begin
            if (idisp_req) begin
                tag0_owner <= OWN_DISP;
            end else if (ant_go && !iant_we) begin
                tag0_owner <= OWN_ANT;
            end else begin
                tag0_owner <= OWN_NONE;
            end
            // During a sweep the RAM is not read, so the data must be zeroed.
            tag0_zero  <= idisp_req && disp_zero;
            tag1_owner <= tag0_owner;
            tag1_zero  <= tag0_zero;

            odisp_valid <= (tag1_owner == OWN_DISP);
            oant_rvalid <= (tag1_owner == OWN_ANT);
            if (tag1_owner == OWN_DISP) begin
                odisp_data <= tag1_zero ? '0 : imem_rdata;
            end
            if (tag1_owner == OWN_ANT) begin
                oant_rdata <= imem_rdata;
            end
        end
    end

    // Frame counter producing one step pulse every STEP_DIV vsync rises.
    always_ff @(posedge iclk) begin
        if (irst) begin
            vs_prev   <= 1'b0;
            frame_cnt <= '0;
            ostep     <= 1'b0;
        end else begin
            vs_prev <= ivs;
            ostep   <= 1'b0;
            if (!ienable || (state != ST_IDLE)) begin
                frame_cnt <= '0;
            end else if (vs_rise) begin
                if (frame_cnt == CNT_LAST) begin
                    frame_cnt <= '0;
                    ostep     <= 1'b1;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_world_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_world_mem_arbiter
//  Description : Scoreboard bench for world_mem_arbiter with a small RAM model
//                (ADDR_W=4, STEP_DIV=3).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_world_mem_arbiter;

    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 3;
    localparam int STEP_DIV = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              vs;
    logic              enable;
    logic              clear;
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_valid;
    logic [DATA_W-1:0] disp_data;
    logic              ant_req;
    logic              ant_we;
    logic [ADDR_W-1:0] ant_addr;
    logic [DATA_W-1:0] ant_wdata;
    logic              ant_ack;
    logic              ant_rvalid;
    logic [DATA_W-1:0] ant_rdata;
    logic              step;
    logic              clear_busy;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    world_mem_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .STEP_DIV (STEP_DIV)
    ) dut (
        .iclk        (clk),
        .irst        (rst),
        .ivs         (vs),
        .ienable     (enable),
        .iclear      (clear),
        .idisp_req   (disp_req),
        .idisp_addr  (disp_addr),
        .odisp_valid (disp_valid),
        .odisp_data  (disp_data),
        .iant_req    (ant_req),
        .iant_we     (ant_we),
        .iant_addr   (ant_addr),
        .iant_wdata  (ant_wdata),
        .oant_ack    (ant_ack),
        .oant_rvalid (ant_rvalid),
        .oant_rdata  (ant_rdata),
        .ostep       (step),
        .oclear_busy (clear_busy),
        .omem_addr   (mem_addr),
        .omem_we     (mem_we),
        .omem_wdata  (mem_wdata),
        .imem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous single-port RAM, one-cycle read latency, plus a backdoor.
    logic [DATA_W-1:0] ram [16];
    logic              bd_we = 1'b0;
    logic [ADDR_W-1:0] bd_addr = '0;
    logic [DATA_W-1:0] bd_data = '0;
    always @(posedge clk) begin
        if (bd_we) ram[bd_addr] <= bd_data;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    typedef struct {
        logic [DATA_W-1:0] data;
        int                at;
    } disp_exp_t;

    disp_exp_t         disp_q[$];
    logic [DATA_W-1:0] ant_q[$];

    int checks     = 0;
    int failures   = 0;
    int ack_count  = 0;
    int last_ack   = -100;
    int step_count = 0;
    int disp_seen  = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT returns read data.
    always @(negedge clk) begin
        if (ant_ack) begin
            ack_count++;
            last_ack = cyc;
        end
        if (step) step_count++;
        if (disp_valid) begin
            disp_seen++;
            if (disp_q.size() == 0) begin
                check("disp_unexpected_valid", 1, 0);
            end else begin
                disp_exp_t e;
                e = disp_q.pop_front();
                check("disp_data", int'(disp_data), int'(e.data));
                check("disp_latency_cycle", cyc, e.at);
            end
        end
        if (ant_rvalid) begin
            if (ant_q.size() == 0) begin
                check("ant_unexpected_rvalid", 1, 0);
            end else begin
                logic [DATA_W-1:0] d;
                d = ant_q.pop_front();
                check("ant_rdata", int'(ant_rdata), int'(d));
                check("ant_rvalid_cycle", cyc, last_ack + 2);
            end
        end
    end

    task automatic bd_write(input int a, input int d);
        @(negedge clk);
        bd_we   = 1'b1;
        bd_addr = ADDR_W'(a);
        bd_data = DATA_W'(d);
        @(negedge clk);
        bd_we   = 1'b0;
    endtask

    task automatic push_disp(input int d);
        disp_q.push_back('{data: DATA_W'(d), at: cyc + 3});
    endtask

    task automatic wait_ack(output int at);
        at = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ant_ack) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic check_sweep(input string name);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check({name, "_we"}, int'(mem_we), 1);
            check({name, "_addr"}, int'(mem_addr), i);
            check({name, "_busy"}, int'(clear_busy), 1);
        end
    endtask

    initial begin
        int c;
        int at;
        int at2;
        int base;
        int fall;
        int ack_busy;
        int nonzero;

        rst = 1'b1; vs = 1'b0; enable = 1'b0; clear = 1'b0;
        disp_req = 1'b0; disp_addr = '0;
        ant_req = 1'b0; ant_we = 1'b0; ant_addr = '0; ant_wdata = '0;

        // Fill RAM with a non-zero colour so the sweep is observable.
        for (int i = 0; i < 16; i++) bd_write(i, 7);

        // Reset values.
        @(negedge clk);
        check("rst_mem_we", int'(mem_we), 0);
        check("rst_mem_addr", int'(mem_addr), 0);
        check("rst_mem_wdata", int'(mem_wdata), 0);
        check("rst_disp_valid", int'(disp_valid), 0);
        check("rst_ant_ack", int'(ant_ack), 0);
        check("rst_ant_rvalid", int'(ant_rvalid), 0);
        check("rst_step", int'(step), 0);
        check("rst_clear_busy", int'(clear_busy), 1);
        rst = 1'b0;

        // Sweep after reset with display reads issued alongside.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("sweep_we", int'(mem_we), 1);
            check("sweep_addr", int'(mem_addr), i);
            check("sweep_wdata", int'(mem_wdata), 0);
            check("sweep_busy", int'(clear_busy), 1);
            disp_req  = 1'b1;
            disp_addr = ADDR_W'(15 - i);
            push_disp(0);
        end
        @(negedge clk);
        disp_req = 1'b0;
        check("sweep_busy_fall", int'(clear_busy), 0);
        check("sweep_idle_we", int'(mem_we), 0);
        repeat (4) @(negedge clk);
        nonzero = 0;
        for (int i = 0; i < 16; i++) if (ram[i] != '0) nonzero++;
        check("sweep_ram_nonzero_cells", nonzero, 0);

        // Back-to-back display reads of preloaded cells.
        bd_write(5, 1);
        bd_write(6, 2);
        bd_write(7, 3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            disp_req  = 1'b1;
            disp_addr = ADDR_W'(5 + i);
            push_disp(i + 1);
        end
        @(negedge clk);
        disp_req = 1'b0;
        repeat (4) @(negedge clk);

        // Ant write then read of address 9.
        base = ack_count;
        @(negedge clk);
        c = cyc;
        ant_req = 1'b1; ant_we = 1'b1; ant_addr = 4'd9; ant_wdata = 3'd6;
        wait_ack(at);
        check("ant_write_ack_cycle", at, c + 1);
        ant_we = 1'b0;
        ant_q.push_back(3'd6);
        wait_ack(at2);
        check("ant_read_ack_cycle", at2, at + 2);
        ant_req = 1'b0;
        repeat (4) @(negedge clk);
        check("ant_ack_count_wr_rd", ack_count - base, 2);

        // Ant starved by 10 cycles of display reads.
        base = ack_count;
        c = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) begin
                c = cyc;
                ant_req = 1'b1; ant_we = 1'b0; ant_addr = 4'd6;
                ant_q.push_back(3'd2);
            end
            check("starve_no_ack", int'(ant_ack), 0);
            disp_req  = 1'b1;
            disp_addr = ADDR_W'(5 + (i % 3));
            push_disp((i % 3) + 1);
        end
        @(negedge clk);
        disp_req = 1'b0;
        check("starve_no_ack_last", int'(ant_ack), 0);
        wait_ack(at);
        check("starve_ack_cycle", at, c + 11);
        ant_req = 1'b0;
        repeat (5) @(negedge clk);
        check("starve_single_ack", ack_count - base, 1);

        // Clear and ant request in the same cycle: clear wins.
        @(negedge clk);
        c = cyc;
        clear = 1'b1;
        ant_req = 1'b1; ant_we = 1'b1; ant_addr = 4'd3; ant_wdata = 3'd5;
        @(negedge clk);
        clear = 1'b0;
        check("clr_busy_rise", int'(clear_busy), 1);
        at = -1; fall = -1; ack_busy = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!clear_busy && fall < 0) fall = cyc;
            if (ant_ack) begin
                at = cyc;
                ack_busy = int'(clear_busy);
                break;
            end
        end
        check("clr_busy_fall_cycle", fall, c + 18);
        check("clr_ant_ack_cycle", at, c + 18);
        check("clr_ant_ack_busy", ack_busy, 0);
        ant_req = 1'b0;
        repeat (3) @(negedge clk);
        check("clr_ram3_written", int'(ram[3]), 5);
        check("clr_ram5_cleared", int'(ram[5]), 0);

        // Step pacing: pulses on edges 3 and 6; enable drop clears the count.
        base = step_count;
        @(negedge clk);
        enable = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            if (e == 9) begin
                @(negedge clk);
                enable = 1'b0;
            end
            @(negedge clk);
            vs = 1'b1;
            @(negedge clk);
            check($sformatf("step_edge%0d", e), int'(step), (e == 3 || e == 6) ? 1 : 0);
            vs = 1'b0;
            repeat (2) @(negedge clk);
        end
        check("step_total", step_count - base, 2);

        // Reset mid-operation drops an in-flight display read.
        base = disp_seen;
        @(negedge clk);
        disp_req  = 1'b1;
        disp_addr = 4'd5;
        @(negedge clk);
        disp_req = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_sweep("rst2_sweep");
        @(negedge clk);
        check("rst2_busy_fall", int'(clear_busy), 0);
        check("rst2_inflight_dropped", disp_seen - base, 0);

        repeat (4) @(negedge clk);
        check("disp_queue_empty", disp_q.size(), 0);
        check("ant_queue_empty", ant_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
